// File: rtl/trans_layer_n_pkg.sv
// Shared types and helpers for the transaction layer: FSM encoding, destination decode, log2 checks.
package trans_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Destination channel sits in the top ch_bits of a data_size-bit word.
    function automatic logic [31:0] get_dest(input logic [31:0] word, input int data_size,
                                             input int ch_bits);
        return (word >> (data_size - ch_bits)) & ((32'd1 << ch_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/trans_layer_n_fifo.sv
// First-word-fall-through queue; head visible combinationally, write and read at the rising edge.
// Writes are dropped when full unless a read frees the slot in the same cycle.
module fifo_fwft #(
    parameter int DATA_SIZE = 12,
    parameter int DEPTH     = 8,
    parameter int PTR_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_dat,
    input  logic                 rd_en,
    input  logic [PTR_BITS-1:0]  th_af,
    input  logic [PTR_BITS-1:0]  th_ae,
    output logic [DATA_SIZE-1:0] rd_dat,
    output logic                 vld,
    output logic                 full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_BITS:0]    count
);
    localparam logic [PTR_BITS:0] DEPTH_C = (PTR_BITS+1)'(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]    cnt_q, cnt_d, af_lvl;
    logic                 wr_ok, rd_ok;

    always_comb begin
        vld          = (cnt_q != '0);
        full         = (cnt_q == DEPTH_C);
        rd_ok        = rd_en && vld;
        wr_ok        = wr_en && (!full || rd_ok);
        wr_ptr_d     = wr_ptr_q + PTR_BITS'(wr_ok);
        rd_ptr_d     = rd_ptr_q + PTR_BITS'(rd_ok);
        cnt_d        = cnt_q + (PTR_BITS+1)'(wr_ok) - (PTR_BITS+1)'(rd_ok);
        // A zero threshold means only a completely full queue counts as almost full.
        af_lvl       = (th_af == '0) ? DEPTH_C : {1'b0, th_af};
        almost_full  = (cnt_q >= af_lvl);
        almost_empty = (cnt_q <= {1'b0, th_ae});
        rd_dat       = mem_q[rd_ptr_q];
        count        = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/trans_layer_n.sv
// Ingress queue dispatched by destination field into N_CHAN egress queues, 2-cycle push-to-valid.
// A head whose egress is almost full stalls the whole ingress; pushes into a full ingress set a sticky error.
module trans_layer_n
    import trans_pkg::*;
#(
    parameter int DATA_SIZE = 12,
    parameter int N_CHAN    = 4,
    parameter int CH_BITS   = 2,
    parameter int DEPTH     = 8,
    parameter int PTR_BITS  = 3,
    parameter int CNT_BITS  = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    input  logic [PTR_BITS-1:0]         th_almost_full,
    input  logic [PTR_BITS-1:0]         th_almost_empty,
    input  logic                        push,
    input  logic [DATA_SIZE-1:0]        data_in,
    output logic                        ingress_full,
    input  logic [N_CHAN-1:0]           pop,
    output logic [N_CHAN*DATA_SIZE-1:0] data_out,
    output logic [N_CHAN-1:0]           valid_out,
    output logic [N_CHAN-1:0]           almost_empty,
    input  logic                        req,
    input  logic [CH_BITS-1:0]          idx,
    output logic [CNT_BITS-1:0]         data_out_cont,
    output logic                        valid_cont,
    output logic                        idle,
    output logic                        error
);
    if (CH_BITS != clog2_f(N_CHAN) || PTR_BITS != clog2_f(DEPTH)) begin : g_param_err
        $error("CH_BITS/PTR_BITS must be log2 of N_CHAN/DEPTH");
    end

    // Index N_CHAN is the ingress queue; 0..N_CHAN-1 are the egress queues.
    logic [N_CHAN:0]        q_wr, q_rd, q_vld, q_full, q_af, q_ae;
    logic [DATA_SIZE-1:0]   q_wdat [N_CHAN+1];
    logic [DATA_SIZE-1:0]   q_rdat [N_CHAN+1];
    logic [PTR_BITS-1:0]    q_thaf [N_CHAN+1];
    logic [PTR_BITS-1:0]    q_thae [N_CHAN+1];

    state_e                 state_q, state_d;
    logic [PTR_BITS-1:0]    th_af_q, th_af_d, th_ae_q, th_ae_d;
    logic [CNT_BITS-1:0]    cnt_q [N_CHAN];
    logic [CNT_BITS-1:0]    cnt_d [N_CHAN];
    logic [CNT_BITS-1:0]    data_out_cont_q, data_out_cont_d;
    logic                   valid_cont_q, valid_cont_d, error_q, error_d;
    logic [DATA_SIZE-1:0]   ing_head;
    logic [CH_BITS-1:0]     dest;
    logic [N_CHAN-1:0]      eg_af;
    logic                   disp;
    logic                   unused_bits;

    for (genvar g = 0; g <= N_CHAN; g++) begin : g_q
        logic [PTR_BITS:0] unused_cnt;
        fifo_fwft #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) u_fifo (
            .clk         (clk),
            .rst         (reset),
            .wr_en       (q_wr[g]),
            .wr_dat      (q_wdat[g]),
            .rd_en       (q_rd[g]),
            .th_af       (q_thaf[g]),
            .th_ae       (q_thae[g]),
            .rd_dat      (q_rdat[g]),
            .vld         (q_vld[g]),
            .full        (q_full[g]),
            .almost_full (q_af[g]),
            .almost_empty(q_ae[g]),
            .count       (unused_cnt)
        );
    end

    assign unused_bits = ^{q_full[N_CHAN-1:0], q_af[N_CHAN], q_ae[N_CHAN]};

    always_comb begin
        ing_head = q_rdat[N_CHAN];
        dest     = CH_BITS'(get_dest(32'(ing_head), DATA_SIZE, CH_BITS));
        eg_af    = q_af[N_CHAN-1:0];
        disp     = (state_q != ST_INIT) && q_vld[N_CHAN] && !eg_af[dest];

        q_wr             = '0;
        q_rd             = '0;
        data_out         = '0;
        q_wr[N_CHAN]     = push;
        q_rd[N_CHAN]     = disp;
        q_wdat[N_CHAN]   = data_in;
        q_thaf[N_CHAN]   = '0;
        q_thae[N_CHAN]   = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            q_wr[c]   = disp && (dest == CH_BITS'(c));
            q_rd[c]   = pop[c];
            q_wdat[c] = ing_head;
            q_thaf[c] = th_af_q;
            q_thae[c] = th_ae_q;
            data_out[c*DATA_SIZE +: DATA_SIZE] = q_rdat[c];
            cnt_d[c]  = (state_q == ST_INIT) ? '0 : cnt_q[c] + CNT_BITS'(pop[c] && q_vld[c]);
        end

        valid_out    = q_vld[N_CHAN-1:0];
        almost_empty = q_ae[N_CHAN-1:0];
        ingress_full = q_full[N_CHAN];
        error_d      = error_q || (push && q_full[N_CHAN] && !disp);
        th_af_d      = init ? th_almost_full : th_af_q;
        th_ae_d      = init ? th_almost_empty : th_ae_q;

        valid_cont_d    = 1'b0;
        data_out_cont_d = data_out_cont_q;
        if (req && state_q == ST_IDLE) begin
            valid_cont_d    = 1'b1;
            data_out_cont_d = cnt_q[idx];
        end

        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (|q_vld) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!(|q_vld)) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
        if (init) state_d = ST_INIT;

        idle          = (state_q == ST_IDLE);
        valid_cont    = valid_cont_q;
        data_out_cont = data_out_cont_q;
        error         = error_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_RESET;
            th_af_q         <= PTR_BITS'(DEPTH - 1);
            th_ae_q         <= PTR_BITS'(1);
            data_out_cont_q <= '0;
            valid_cont_q    <= 1'b0;
            error_q         <= 1'b0;
            for (int c = 0; c < N_CHAN; c++) cnt_q[c] <= '0;
        end else begin
            state_q         <= state_d;
            th_af_q         <= th_af_d;
            th_ae_q         <= th_ae_d;
            data_out_cont_q <= data_out_cont_d;
            valid_cont_q    <= valid_cont_d;
            error_q         <= error_d;
            for (int c = 0; c < N_CHAN; c++) cnt_q[c] <= cnt_d[c];
        end
    end

endmodule
